// File: rtl/fixed_float_pkg.sv
// Shared IEEE-754 single-precision constants and the packed float layout
// used by the fixed-to-float converter.
package fixed_float_pkg;

    localparam int F32_BIAS  = 127;
    localparam int F32_EXP_W = 8;
    localparam int F32_MAN_W = 23;

    typedef struct packed {
        logic                 sign;
        logic [F32_EXP_W-1:0] exp;
        logic [F32_MAN_W-1:0] frac;
    } f32_t;

endpackage

// File: rtl/lead_one_detect.sv
// Combinational leading-one detector: a binary reduction tree over the operand
// padded to a power of two, returning the index of the highest set bit.
module lead_one_detect #(
    parameter int W  = 32,
    parameter int LW = $clog2(W)
) (
    input  logic [W-1:0]  i_mag,
    output logic [LW-1:0] o_msb,
    output logic          o_zero
);
    localparam int P = 1 << LW;

    logic [P-1:0]  w_pad;
    logic          w_v  [LW+1][P];
    logic [LW-1:0] w_id [LW+1][P];

    assign w_pad = P'(i_mag);

    // Each node keeps the absolute index of the highest one in its subtree.
    always_comb begin
        for (int l = 0; l <= LW; l++) begin
            for (int n = 0; n < P; n++) begin
                w_v[l][n]  = 1'b0;
                w_id[l][n] = '0;
            end
        end
        for (int n = 0; n < P; n++) begin
            w_v[0][n]  = w_pad[n];
            w_id[0][n] = LW'(n);
        end
        for (int l = 1; l <= LW; l++) begin
            for (int n = 0; n < (P >> l); n++) begin
                w_v[l][n]  = w_v[l-1][2*n+1] | w_v[l-1][2*n];
                w_id[l][n] = w_v[l-1][2*n+1] ? w_id[l-1][2*n+1] : w_id[l-1][2*n];
            end
        end
    end

    assign o_msb  = w_id[LW][0];
    assign o_zero = !w_v[LW][0];

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Three-stage fixed-point to IEEE-754 single converter (sign/magnitude, normalise,
// round-to-nearest-even and pack) behind a global-enable valid/ready pipeline.
module fixed_to_float_pipe
    import fixed_float_pkg::*;
#(
    parameter int IN_W = 32,
    parameter int PW   = $clog2(IN_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    input  logic [PW-1:0]   in_fixpointpos,
    input  logic            in_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic            out_inexact
);
    // Normalised word widened so guard and sticky always exist below the 24-bit significand.
    localparam int EXT = (IN_W > 26) ? IN_W : 26;

    logic              w_advance;
    logic              w_sign_s1;
    logic [IN_W-1:0]   w_mag_s1;

    logic              r_vld_p0;
    logic              r_sign_p0;
    logic [IN_W-1:0]   r_mag_p0;
    logic [PW-1:0]     r_pos_p0;

    logic [PW-1:0]     w_msb;
    logic              w_zero;
    logic [PW-1:0]     w_shamt;
    logic [IN_W-1:0]   w_norm;
    logic signed [8:0] w_exp;

    logic              r_vld_p1;
    logic              r_sign_p1;
    logic [IN_W-1:0]   r_norm_p1;
    logic signed [8:0] r_exp_p1;

    logic [EXT-1:0]    w_ext;
    logic [24:0]       w_sum;
    logic              w_inexact;
    f32_t              w_res;

    // Returns {inexact, rounded significand}; bit 24 of the significand is the carry-out.
    function automatic logic [25:0] rne_round(input logic [EXT-1:0] ext);
        logic [23:0] sig;
        logic        guard;
        logic        sticky;
        sig    = ext[EXT-1 -: 24];
        guard  = ext[EXT-25];
        sticky = |ext[EXT-26:0];
        return {guard | sticky, {1'b0, sig} + 25'(guard & (sticky | sig[0]))};
    endfunction

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // Stage 1: sign/magnitude
    assign w_sign_s1 = in_signed & in_data[IN_W-1];
    assign w_mag_s1  = w_sign_s1 ? -in_data : in_data;

    // Stage 2: normalise
    lead_one_detect #(.W(IN_W), .LW(PW)) u_lod (
        .i_mag  (r_mag_p0),
        .o_msb  (w_msb),
        .o_zero (w_zero)
    );

    assign w_shamt = PW'(IN_W - 1) - w_msb;
    assign w_norm  = r_mag_p0 << w_shamt;
    // A zero magnitude gets exponent 0 so the packer emits +0 with no special case.
    assign w_exp   = w_zero ? 9'sd0 : 9'(w_msb) - 9'(r_pos_p0) + 9'(F32_BIAS);

    // Stage 3: round and pack
    assign w_ext              = EXT'(r_norm_p1) << (EXT - IN_W);
    assign {w_inexact, w_sum} = rne_round(w_ext);
    assign w_res              = {r_sign_p1, 8'(r_exp_p1 + 9'(w_sum >> 24)), 23'(w_sum)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= 32'h0;
            out_inexact <= 1'b0;
        end else if (w_advance) begin
            r_vld_p0  <= in_valid & in_ready;
            r_vld_p1  <= r_vld_p0;
            out_valid <= r_vld_p1;
            if (r_vld_p1) begin
                out_result  <= w_res;
                out_inexact <= w_inexact;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_sign_p0 <= w_sign_s1;
            r_mag_p0  <= w_mag_s1;
            r_pos_p0  <= in_fixpointpos;
            r_sign_p1 <= r_sign_p0;
            r_norm_p1 <= w_norm;
            r_exp_p1  <= w_exp;
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Bench for fixed_to_float_pipe: directed conversions, random streams against a
// double-precision reference, mid-flight reset and 16/64-bit parameter variants.
module tb_fixed_to_float_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_inexact;
    logic [31:0] in_data, out_result;
    logic [4:0]  in_fixpointpos;

    logic        v16_in_valid, v16_in_ready, v16_in_signed, v16_out_valid, v16_out_ready, v16_out_inexact;
    logic [15:0] v16_in_data;
    logic [3:0]  v16_pos;
    logic [31:0] v16_out_result;

    logic        v64_in_valid, v64_in_ready, v64_in_signed, v64_out_valid, v64_out_ready, v64_out_inexact;
    logic [63:0] v64_in_data;
    logic [5:0]  v64_pos;
    logic [31:0] v64_out_result;

    int total = 0;
    int bad   = 0;

    fixed_to_float_pipe #(.IN_W(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_fixpointpos(in_fixpointpos), .in_signed(in_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_inexact(out_inexact)
    );

    fixed_to_float_pipe #(.IN_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(v16_in_valid), .in_ready(v16_in_ready), .in_data(v16_in_data),
        .in_fixpointpos(v16_pos), .in_signed(v16_in_signed), .out_valid(v16_out_valid),
        .out_ready(v16_out_ready), .out_result(v16_out_result), .out_inexact(v16_out_inexact)
    );

    fixed_to_float_pipe #(.IN_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(v64_in_valid), .in_ready(v64_in_ready), .in_data(v64_in_data),
        .in_fixpointpos(v64_pos), .in_signed(v64_in_signed), .out_valid(v64_out_valid),
        .out_ready(v64_out_ready), .out_result(v64_out_result), .out_inexact(v64_out_inexact)
    );

    // Reference: exact value as a double, then IEEE rounding of the double down to single.
    task automatic ref_f32(input logic [31:0] d, input int pos, input logic s,
                           output logic [31:0] res, output logic inex);
        longint      m;
        real         r;
        logic [63:0] b;
        int          e;
        logic [24:0] sig;
        logic [28:0] rem;
        logic        neg;
        neg = s && d[31];
        m   = longint'({32'b0, d});
        if (neg) m = 64'sh1_0000_0000 - m;
        if (m == 0) begin
            res  = 32'h0;
            inex = 1'b0;
        end else begin
            r = real'(m);
            for (int i = 0; i < pos; i++) r = r / 2.0;
            b   = $realtobits(r);
            e   = int'(b[62:52]) - 1023 + 127;
            sig = {2'b01, b[51:29]};
            rem = b[28:0];
            if (rem[28] && ((|rem[27:0]) || sig[0])) sig = sig + 25'd1;
            if (sig[24]) begin
                e   = e + 1;
                sig = sig >> 1;
            end
            res  = {neg, 8'(e), sig[22:0]};
            inex = |rem;
        end
    endtask

    // Drives one word into the empty 32-bit pipeline and waits for its result.
    task automatic send_one(input logic [31:0] d, input int pos, input logic s,
                            output logic [31:0] r, output logic x, output int lat);
        out_ready      = 1'b1;
        in_data        = d;
        in_fixpointpos = 5'(pos);
        in_signed      = s;
        in_valid       = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = out_result;
        x = out_inexact;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_fixpointpos = '0; in_signed = 1'b0;
        v16_in_valid = 1'b0; v16_out_ready = 1'b1; v16_in_data = '0; v16_pos = '0; v16_in_signed = 1'b0;
        v64_in_valid = 1'b0; v64_out_ready = 1'b1; v64_in_data = '0; v64_pos = '0; v64_in_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h want=00000000", out_result); end
        total++; if (out_inexact !== 1'b0) begin bad++; $display("FAIL reset_out_inexact got=%b want=0", out_inexact); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_basic();
        logic [31:0] vd [8] = '{32'h00000100, 32'hFFFFFFE8, 32'h00000000, 32'h01000001,
                                32'h01000003, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        int          vp [8] = '{8, 4, 0, 0, 0, 0, 0, 0};
        logic        vs [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] vr [8] = '{32'h3F800000, 32'hBFC00000, 32'h00000000, 32'h4B800000,
                                32'h4B800002, 32'h4F800000, 32'hBF800000, 32'hCF000000};
        logic        vx [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] r;
        logic        x;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            send_one(vd[i], vp[i], vs[i], r, x, lat);
            total++; if (lat !== 3) begin bad++; $display("FAIL basic%0d_latency got=%0d want=3", i, lat); end
            total++; if (r !== vr[i]) begin bad++; $display("FAIL basic%0d_result got=%h want=%h", i, r, vr[i]); end
            total++; if (x !== vx[i]) begin bad++; $display("FAIL basic%0d_inexact got=%b want=%b", i, x, vx[i]); end
        end
    endtask

    // Random stream; every cycle with out_valid high, the held result is checked against the oldest expectation.
    task automatic test_stream(input string tag, input int n, input int rdy_pct, input int vld_pct);
        logic [32:0] q[$];
        logic [31:0] d, r;
        logic        x, s, hs;
        int          pos;
        int          sent = 0, got = 0, cyc = 0;
        in_valid = 1'b0;
        while (got < n && cyc < 3000) begin
            if (!in_valid && sent < n && int'($urandom_range(99, 0)) < vld_pct) begin
                d = $urandom;
                case ($urandom_range(3, 0))
                    0: d = d >> $urandom_range(31, 0);
                    1: d = ~(d >> $urandom_range(31, 0));
                    default: ;
                endcase
                pos = int'($urandom_range(31, 0));
                s   = 1'($urandom_range(1, 0));
                ref_f32(d, pos, s, r, x);
                q.push_back({x, r});
                in_data = d; in_fixpointpos = 5'(pos); in_signed = s; in_valid = 1'b1;
            end
            out_ready = (int'($urandom_range(99, 0)) < rdy_pct);
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL %s_stale got=%h with no word outstanding", tag, out_result);
                end else if ({out_inexact, out_result} !== q[0]) begin
                    bad++; $display("FAIL %s_data got=%b/%h want=%b/%h", tag, out_inexact, out_result, q[0][32], q[0][31:0]);
                end
                if (out_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    got++;
                end
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) begin
                in_valid = 1'b0;
                sent++;
            end
            cyc++;
        end
        total++; if (got != n) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tag, got, n); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_extra got=%b want=0", tag, out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r;
        logic        x;
        int          lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom; in_fixpointpos = 5'($urandom_range(31, 0)); in_signed = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midflight_busy got=%b want=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midflight_valid got=%b want=0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL midflight_result got=%h want=00000000", out_result); end
        total++; if (out_inexact !== 1'b0) begin bad++; $display("FAIL midflight_inexact got=%b want=0", out_inexact); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midflight_in_ready got=%b want=1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midflight_stale%0d got=%b want=0", i, out_valid); end
            @(posedge clk); #1;
        end
        send_one(32'h00000300, 8, 1'b0, r, x, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL midflight_latency got=%0d want=3", lat); end
        total++; if (r !== 32'h40400000) begin bad++; $display("FAIL midflight_first got=%h want=40400000", r); end
    endtask

    task automatic test_param_sweep();
        logic [15:0] d16 [2] = '{16'h8000, 16'h0001};
        logic [31:0] r16 [2] = '{32'hBF800000, 32'h38000000};
        logic [63:0] d64 [2] = '{64'h0020_0000_0000_0001, 64'h8000_0000_0000_0000};
        logic        s64 [2] = '{1'b0, 1'b1};
        logic [31:0] r64 [2] = '{32'h5A000000, 32'hDF000000};
        logic        x64 [2] = '{1'b1, 1'b0};
        int          lat;
        for (int i = 0; i < 2; i++) begin
            total++; if (v16_in_ready !== 1'b1) begin bad++; $display("FAIL sweep16_ready got=%b want=1", v16_in_ready); end
            v16_in_data = d16[i]; v16_pos = 4'd15; v16_in_signed = 1'b1; v16_in_valid = 1'b1;
            @(posedge clk); #1;
            v16_in_valid = 1'b0;
            lat = 1;
            while (!v16_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            total++; if (lat !== 3) begin bad++; $display("FAIL sweep16_%0d_latency got=%0d want=3", i, lat); end
            total++; if (v16_out_result !== r16[i]) begin bad++; $display("FAIL sweep16_%0d_result got=%h want=%h", i, v16_out_result, r16[i]); end
            total++; if (v16_out_inexact !== 1'b0) begin bad++; $display("FAIL sweep16_%0d_inexact got=%b want=0", i, v16_out_inexact); end
            repeat (2) @(posedge clk);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            total++; if (v64_in_ready !== 1'b1) begin bad++; $display("FAIL sweep64_ready got=%b want=1", v64_in_ready); end
            v64_in_data = d64[i]; v64_pos = 6'd0; v64_in_signed = s64[i]; v64_in_valid = 1'b1;
            @(posedge clk); #1;
            v64_in_valid = 1'b0;
            lat = 1;
            while (!v64_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            total++; if (lat !== 3) begin bad++; $display("FAIL sweep64_%0d_latency got=%0d want=3", i, lat); end
            total++; if (v64_out_result !== r64[i]) begin bad++; $display("FAIL sweep64_%0d_result got=%h want=%h", i, v64_out_result, r64[i]); end
            total++; if (v64_out_inexact !== x64[i]) begin bad++; $display("FAIL sweep64_%0d_inexact got=%b want=%b", i, v64_out_inexact, x64[i]); end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stream("back_to_back", 24, 100, 100);
        test_stream("backpressure", 30, 50, 70);
        test_reset_midflight();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
